// File: rtl/isa_test_tohost_monitor_if.sv
// AXI4-Lite slave-side bundle for the tohost monitor: write address, write
// data, write response, read address and read data channels.
interface isa_test_tohost_monitor_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/isa_test_tohost_monitor.sv
// riscv-tests "tohost" endpoint. Decodes writes to the tohost word into a
// sticky done/pass verdict with the failing test number, counts cycles until
// the verdict, and fires a watchdog if the program never reports.
//
// A write commits on the edge where both its address and data are available,
// either from the one-entry buffers or from a handshake on that same edge, so
// a same-cycle AW+W gets its response on the next cycle. A new commit waits
// for the previous response to be accepted.
module isa_test_tohost_monitor #(
    parameter logic [31:0] TO_HOST_ADDR   = 32'h3000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int          SIM_DELAY      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    isa_test_tohost_monitor_if.slave      s_axi,
    output logic                          test_done,
    output logic                          test_pass,
    output logic                          test_timeout,
    output logic [30:0]                   fail_testnum,
    output logic [31:0]                   cycle_cnt
);

    // Register updates are modelled with zero delay; SIM_DELAY is kept only so
    // existing instantiations still elaborate, and must be non-negative.
    if (SIM_DELAY < 0) begin : g_bad_sim_delay
        $error("SIM_DELAY must be non-negative");
    end

    localparam logic [31:0] ADDR_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] TOHOST_WORD  = TO_HOST_ADDR & ADDR_MASK;
    localparam logic        WDOG_EN      = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    logic        aw_full, w_full;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic [31:0] tohost;

    logic        aw_hs, w_hs, ar_hs;
    logic        aw_avail, w_avail, commit;
    logic [31:0] cm_addr, cm_data, merged;
    logic [3:0]  cm_strb;
    logic        wr_hit, rd_hit, verdict, wd_fire;

    // Handshakes, commit selection, byte merge and verdict/watchdog decisions.
    always_comb begin
        aw_hs    = s_axi.awvalid & awready_q;
        w_hs     = s_axi.wvalid & wready_q;
        ar_hs    = s_axi.arvalid & arready_q;
        aw_avail = aw_full | aw_hs;
        w_avail  = w_full | w_hs;
        commit   = aw_avail & w_avail & ~bvalid_q;
        cm_addr  = aw_full ? aw_addr_q : s_axi.awaddr;
        cm_data  = w_full ? w_data_q : s_axi.wdata;
        cm_strb  = w_full ? w_strb_q : s_axi.wstrb;
        wr_hit   = (cm_addr & ADDR_MASK) == TOHOST_WORD;
        rd_hit   = (s_axi.araddr & ADDR_MASK) == TOHOST_WORD;
        merged   = tohost;
        for (int b = 0; b < 4; b++) begin
            if (cm_strb[b]) merged[b*8 +: 8] = cm_data[b*8 +: 8];
        end
        verdict  = commit & wr_hit & ~test_done & merged[0];
        wd_fire  = WDOG_EN & ~test_done & ~verdict & (cycle_cnt == TIMEOUT_LAST);
    end

    // Write channel: AW/W buffers, tohost storage and the B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            tohost    <= '0;
        end else begin
            aw_full   <= aw_avail & ~commit;
            w_full    <= w_avail & ~commit;
            awready_q <= ~(aw_avail & ~commit);
            wready_q  <= ~(w_avail & ~commit);
            if (aw_hs) aw_addr_q <= s_axi.awaddr;
            if (w_hs) begin
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_hit ? 2'b00 : 2'b11;
                if (wr_hit) tohost <= merged;
            end else if (bvalid_q & s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read channel: single outstanding read, arready mirrors ~rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else if (rvalid_q) begin
            if (s_axi.rready) rvalid_q <= 1'b0;
            arready_q <= s_axi.rready;
        end else if (ar_hs) begin
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rdata_q   <= rd_hit ? tohost : 32'h0;
            rresp_q   <= rd_hit ? 2'b00 : 2'b11;
        end else begin
            arready_q <= 1'b1;
        end
    end

    // Verdict capture, watchdog and the cycle counter that freezes with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_timeout <= 1'b0;
            fail_testnum <= '0;
            cycle_cnt    <= '0;
        end else if (verdict) begin
            test_done    <= 1'b1;
            test_pass    <= (merged == 32'h1);
            fail_testnum <= merged[31:1];
        end else if (wd_fire) begin
            test_done    <= 1'b1;
            test_pass    <= 1'b0;
            test_timeout <= 1'b1;
        end else if (!test_done && cycle_cnt != 32'hFFFF_FFFF) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_isa_test_tohost_monitor.sv
// Bench for isa_test_tohost_monitor: a table of single-write vectors, hand
// sequences for response back-pressure, reset and the watchdog, and a random
// run checked against a byte-level model of tohost and the verdict rules.
module tb_isa_test_tohost_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_t;
    logic        done_a, pass_a, tmo_a, done_t, pass_t, tmo_t;
    logic [30:0] num_a, num_t;
    logic [31:0] cnt_a, cnt_t;

    isa_test_tohost_monitor_if bus_a ();
    isa_test_tohost_monitor_if bus_t ();

    isa_test_tohost_monitor #(.TO_HOST_ADDR(32'h3000), .TIMEOUT_CYCLES(32'd0), .SIM_DELAY(1)) dut_a (
        .clk(clk), .rst(rst_a), .s_axi(bus_a),
        .test_done(done_a), .test_pass(pass_a), .test_timeout(tmo_a),
        .fail_testnum(num_a), .cycle_cnt(cnt_a)
    );

    isa_test_tohost_monitor #(.TO_HOST_ADDR(32'h3000), .TIMEOUT_CYCLES(32'd100), .SIM_DELAY(1)) dut_t (
        .clk(clk), .rst(rst_t), .s_axi(bus_t),
        .test_done(done_t), .test_pass(pass_t), .test_timeout(tmo_t),
        .fail_testnum(num_t), .cycle_cnt(cnt_t)
    );

    int nvec  = 0;
    int nfail = 0;

    // Edges seen with rst_a low since the last reset of dut_a.
    int edges_a = 0;
    always @(posedge clk) edges_a <= rst_a ? 0 : edges_a + 1;

    // Reference model of dut_a.
    logic [31:0] m_tohost;
    logic        m_done, m_pass;
    logic [30:0] m_num;
    int          m_frozen;

    logic [31:0] miss_addrs [5] = '{32'h2000, 32'h3004, 32'h0, 32'h2FFC, 32'hFFFF_F000};

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [31:0] rd_addr;
        logic [1:0]  bresp;
        logic        done;
        logic        pass;
        logic [30:0] num;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_bus_a();
        bus_a.awaddr = '0; bus_a.awvalid = 1'b0; bus_a.wdata = '0; bus_a.wstrb = '0;
        bus_a.wvalid = 1'b0; bus_a.bready = 1'b1; bus_a.araddr = '0; bus_a.arvalid = 1'b0;
        bus_a.rready = 1'b1;
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        idle_bus_a();
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        m_tohost = '0; m_done = 1'b0; m_pass = 1'b0; m_num = '0; m_frozen = 0;
    endtask

    // Starts and ends at a negedge. lat = edges between the last handshake
    // edge's negedge and bvalid being seen (0 = response the next cycle).
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd, output logic [1:0] resp, output int lat);
        bit aw_ok, w_ok, aw_now, w_now;
        int cyc;
        aw_ok = 0; w_ok = 0; cyc = 0; lat = -1; resp = 2'bxx;
        bus_a.awaddr = a; bus_a.wdata = d; bus_a.wstrb = s;
        while (!(aw_ok && w_ok) && cyc < 40) begin
            bus_a.awvalid = !aw_ok && cyc >= awd;
            bus_a.wvalid  = !w_ok && cyc >= wd;
            aw_now = bus_a.awvalid && bus_a.awready;
            w_now  = bus_a.wvalid && bus_a.wready;
            @(posedge clk);
            aw_ok = aw_ok | aw_now;
            w_ok  = w_ok | w_now;
            @(negedge clk);
            cyc++;
        end
        bus_a.awvalid = 1'b0;
        bus_a.wvalid  = 1'b0;
        if (!(aw_ok && w_ok)) return;
        lat = 0;
        while (!bus_a.bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        resp = bus_a.bresp;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
        bit ok;
        int cyc;
        ok = 0; cyc = 0; lat = -1; data = 'x; resp = 2'bxx;
        bus_a.araddr = a;
        while (!ok && cyc < 40) begin
            bus_a.arvalid = 1'b1;
            ok = bus_a.arready;
            @(negedge clk);
            cyc++;
        end
        bus_a.arvalid = 1'b0;
        if (!ok) return;
        lat = 0;
        while (!bus_a.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = bus_a.rdata;
        resp = bus_a.rresp;
        @(negedge clk);
    endtask

    // Model update for a committed write, called at the negedge bvalid is seen.
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        if (a[31:2] != 30'(32'h3000 >> 2)) return;
        v = m_tohost;
        for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        m_tohost = v;
        if (!m_done && v[0]) begin
            m_done = 1'b1;
            m_pass = (v == 32'd1);
            m_num  = v[31:1];
            m_frozen = edges_a - 1;
        end
    endtask

    logic [31:0] rd;
    logic [1:0]  resp, rresp;
    int          lat, rlat, frozen;

    initial begin
        rst_a = 1'b1; rst_t = 1'b1;
        idle_bus_a();
        bus_t.awaddr = '0; bus_t.awvalid = 1'b0; bus_t.wdata = '0; bus_t.wstrb = '0;
        bus_t.wvalid = 1'b0; bus_t.bready = 1'b1; bus_t.araddr = '0; bus_t.arvalid = 1'b0;
        bus_t.rready = 1'b1;

        //           addr          data           strb   aw w  rd_addr     bresp done pass num           rdata          rresp
        vecs[0]  = '{32'h3000, 32'h0000_0001, 4'hF, 0, 0, 32'h3000, 2'b00, 1, 1, 31'd0,         32'h0000_0001, 2'b00};
        vecs[1]  = '{32'h3000, 32'h0000_000B, 4'hF, 3, 0, 32'h3000, 2'b00, 1, 0, 31'd5,         32'h0000_000B, 2'b00};
        vecs[2]  = '{32'h3000, 32'h0000_0004, 4'hF, 0, 0, 32'h3000, 2'b00, 0, 0, 31'd0,         32'h0000_0004, 2'b00};
        vecs[3]  = '{32'h2000, 32'h0000_0001, 4'hF, 0, 0, 32'h3000, 2'b11, 0, 0, 31'd0,         32'h0000_0000, 2'b00};
        vecs[4]  = '{32'h3003, 32'h0000_0007, 4'hF, 1, 1, 32'h3000, 2'b00, 1, 0, 31'd3,         32'h0000_0007, 2'b00};
        vecs[5]  = '{32'h3000, 32'hFFFF_FF01, 4'h1, 0, 2, 32'h3000, 2'b00, 1, 1, 31'd0,         32'h0000_0001, 2'b00};
        vecs[6]  = '{32'h3000, 32'h1234_5678, 4'h2, 0, 0, 32'h3000, 2'b00, 0, 0, 31'd0,         32'h0000_5600, 2'b00};
        vecs[7]  = '{32'h3000, 32'h8000_0001, 4'hF, 2, 5, 32'h3000, 2'b00, 1, 0, 31'h4000_0000, 32'h8000_0001, 2'b00};
        vecs[8]  = '{32'h3004, 32'h0000_0001, 4'hF, 0, 0, 32'h3000, 2'b11, 0, 0, 31'd0,         32'h0000_0000, 2'b00};
        vecs[9]  = '{32'h3000, 32'h0000_0002, 4'hF, 0, 0, 32'h3008, 2'b00, 0, 0, 31'd0,         32'h0000_0000, 2'b11};
        vecs[10] = '{32'h3000, 32'h0000_0003, 4'h0, 0, 0, 32'h3000, 2'b00, 0, 0, 31'd0,         32'h0000_0000, 2'b00};

        reset_a();
        chk("reset_done", done_a, 0);
        chk("reset_cnt", cnt_a, 1);
        chk("reset_tohost_bvalid", bus_a.bvalid, 0);

        // Table vectors, each from a fresh reset.
        foreach (vecs[i]) begin
            reset_a();
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, resp, lat);
            chk($sformatf("v%0d_blat", i), lat, 0);
            chk($sformatf("v%0d_bresp", i), resp, vecs[i].bresp);
            chk($sformatf("v%0d_done", i), done_a, vecs[i].done);
            chk($sformatf("v%0d_pass", i), pass_a, vecs[i].pass);
            chk($sformatf("v%0d_num", i), num_a, vecs[i].num);
            chk($sformatf("v%0d_cnt", i), cnt_a, vecs[i].done ? edges_a - 1 : edges_a);
            chk($sformatf("v%0d_tmo", i), tmo_a, 0);
            @(negedge clk);
            chk($sformatf("v%0d_bclr", i), bus_a.bvalid, 0);
            axi_read(vecs[i].rd_addr, rd, rresp, rlat);
            chk($sformatf("v%0d_rlat", i), rlat, 0);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_rresp", i), rresp, vecs[i].rresp);
        end

        // Writes after the verdict update tohost but leave verdict and count frozen.
        reset_a();
        axi_write(32'h3000, 32'h3, 4'hF, 0, 0, resp, lat);
        frozen = edges_a - 1;
        chk("post_first_num", num_a, 1);
        repeat (5) @(negedge clk);
        axi_write(32'h3000, 32'h1, 4'hF, 0, 0, resp, lat);
        chk("post_bresp", resp, 2'b00);
        chk("post_done", done_a, 1);
        chk("post_pass", pass_a, 0);
        chk("post_num", num_a, 1);
        chk("post_cnt", cnt_a, frozen);
        @(negedge clk);
        axi_read(32'h3000, rd, rresp, rlat);
        chk("post_rdata", rd, 32'h1);

        // Held response blocks the next commit; buffered write commits after B.
        reset_a();
        bus_a.bready = 1'b0;
        axi_write(32'h3000, 32'h4, 4'hF, 0, 0, resp, lat);
        bus_a.awaddr = 32'h2000; bus_a.awvalid = 1'b1;
        bus_a.wdata = 32'h1; bus_a.wstrb = 4'hF; bus_a.wvalid = 1'b1;
        @(negedge clk);
        bus_a.awvalid = 1'b0; bus_a.wvalid = 1'b0;
        chk("hold_awready", bus_a.awready, 0);
        chk("hold_wready", bus_a.wready, 0);
        repeat (3) @(negedge clk);
        chk("hold_bvalid", bus_a.bvalid, 1);
        chk("hold_bresp", bus_a.bresp, 2'b00);
        bus_a.bready = 1'b1;
        @(negedge clk);
        chk("hold_bclr", bus_a.bvalid, 0);
        @(negedge clk);
        chk("hold_b2valid", bus_a.bvalid, 1);
        chk("hold_b2resp", bus_a.bresp, 2'b11);
        @(negedge clk);
        chk("hold_b2clr", bus_a.bvalid, 0);

        // Reset during a held response drops everything.
        reset_a();
        bus_a.bready = 1'b0;
        axi_write(32'h3000, 32'h1, 4'hF, 0, 0, resp, lat);
        bus_a.awaddr = 32'h3000; bus_a.awvalid = 1'b1;
        @(negedge clk);
        bus_a.awvalid = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("rst_outs", {bus_a.awready, bus_a.wready, bus_a.bvalid, bus_a.bresp, bus_a.arready,
                         bus_a.rvalid, bus_a.rresp, done_a, pass_a, tmo_a}, 0);
        chk("rst_vals", {num_a, cnt_a, bus_a.rdata}, 0);
        bus_a.bready = 1'b1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("rst_rel_awready", bus_a.awready, 1);
        axi_read(32'h3000, rd, rresp, rlat);
        chk("rst_tohost", rd, 0);

        // Watchdog boundary on the TIMEOUT_CYCLES=100 instance.
        @(negedge clk);
        rst_t = 1'b0;
        repeat (99) @(negedge clk);
        chk("wd_pre_tmo", tmo_t, 0);
        chk("wd_pre_cnt", cnt_t, 99);
        @(negedge clk);
        chk("wd_tmo", tmo_t, 1);
        chk("wd_done", done_t, 1);
        chk("wd_pass", pass_t, 0);
        chk("wd_cnt", cnt_t, 99);
        repeat (5) @(negedge clk);
        chk("wd_cnt_frozen", cnt_t, 99);

        // Verdict commit on the timeout edge wins.
        rst_t = 1'b1;
        repeat (2) @(negedge clk);
        rst_t = 1'b0;
        repeat (99) @(negedge clk);
        bus_t.awaddr = 32'h3000; bus_t.awvalid = 1'b1;
        bus_t.wdata = 32'h1; bus_t.wstrb = 4'hF; bus_t.wvalid = 1'b1;
        @(negedge clk);
        bus_t.awvalid = 1'b0; bus_t.wvalid = 1'b0;
        chk("race_done", done_t, 1);
        chk("race_pass", pass_t, 1);
        chk("race_tmo", tmo_t, 0);
        chk("race_bvalid", bus_t.bvalid, 1);
        chk("race_cnt", cnt_t, 99);

        // Random traffic against the model.
        reset_a();
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            bit hit;
            if ($urandom_range(0, 24) == 0) reset_a();
            hit = $urandom_range(0, 2) != 0;
            a = hit ? (32'h3000 | 32'($urandom_range(0, 3))) : miss_addrs[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) < 6) begin
                d = $urandom;
                if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
                if ($urandom_range(0, 15) == 0) d = 32'h1;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat);
                model_write(a, d, s);
                chk("rnd_blat", lat, 0);
                chk("rnd_bresp", resp, hit ? 2'b00 : 2'b11);
                chk("rnd_verdict", {done_a, pass_a, num_a}, {m_done, m_pass, m_num});
                chk("rnd_cnt", cnt_a, m_done ? m_frozen : edges_a);
                @(negedge clk);
            end else begin
                axi_read(a, rd, rresp, rlat);
                chk("rnd_rlat", rlat, 0);
                chk("rnd_rdata", rd, hit ? m_tohost : 32'h0);
                chk("rnd_rresp", rresp, hit ? 2'b00 : 2'b11);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete, %0d vectors applied", nvec);
        $fatal(1);
    end

endmodule
